// File: rtl/switch_debouncer_if.sv
// Signal bundle between the raw switch pins, the debouncer and the MCU.
// The slave modport is the debouncer; the master modport is its environment.
interface switch_debouncer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] SW_RAW;
    logic [WIDTH-1:0] SWITCHES;
    logic             SW_CHANGED;
    logic [WIDTH-1:0] CHANGE_MASK;
    logic             INTR;
    logic             INTR_ACK;

    modport slave (
        input  SW_RAW,
        input  INTR_ACK,
        output SWITCHES,
        output SW_CHANGED,
        output CHANGE_MASK,
        output INTR
    );

    modport master (
        output SW_RAW,
        output INTR_ACK,
        input  SWITCHES,
        input  SW_CHANGED,
        input  CHANGE_MASK,
        input  INTR
    );
endinterface

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus independent per-bit debounce counters with edge reporting.
// Optional macro SW_INTR_LATCH_EN turns INTR into a sticky flag cleared by INTR_ACK.
module switch_debouncer #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              CLK,
    input  logic              RST,
    switch_debouncer_if.slave bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_switches;
    logic [WIDTH-1:0] r_mask;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_flip;
    logic [CNT_W-1:0] w_cnt_next [WIDTH];

    // A bit flips on the edge where its mismatch run reaches DEBOUNCE_CYCLES.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign w_diff[gi]     = r_s2[gi] ^ r_switches[gi];
            assign w_flip[gi]     = w_diff[gi] && (r_cnt[gi] == CNT_MAX);
            assign w_cnt_next[gi] = (w_diff[gi] && !w_flip[gi]) ? r_cnt[gi] + 1'b1 : '0;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_switches <= '0;
            r_mask     <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1       <= bus.SW_RAW;
            r_s2       <= r_s1;
            r_switches <= r_switches ^ w_flip;
            r_mask     <= w_flip;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

    assign bus.SWITCHES    = r_switches;
    assign bus.CHANGE_MASK = r_mask;
    assign bus.SW_CHANGED  = |r_mask;

`ifdef SW_INTR_LATCH_EN
    logic r_intr;

    // Set has priority over acknowledge so a change on the ack edge is not lost.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_intr <= 1'b0;
        end else if (|r_mask) begin
            r_intr <= 1'b1;
        end else if (bus.INTR_ACK) begin
            r_intr <= 1'b0;
        end
    end

    assign bus.INTR = r_intr;
`else
    logic w_unused_ack;

    assign w_unused_ack = bus.INTR_ACK;
    assign bus.INTR     = |r_mask;
`endif
endmodule

// File: tb/tb_switch_debouncer.sv
// Randomised and directed bench for switch_debouncer against a sample-history reference model.
module tb_switch_debouncer;
    localparam int W   = 16;
    localparam int DEB = 4;

    logic CLK;
    logic RST;
    int   n_checks;
    int   n_errors;

    switch_debouncer_if #(.WIDTH(W)) bus ();

    switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: a bit is accepted once the last DEB synchronised samples all differ from it.
    logic [W-1:0] m_s1, m_s2, m_sw, m_mask, m_acc;
    logic         m_intr, m_all;
    logic [W-1:0] hist [$];

    always @(posedge CLK) begin
        if (RST) begin
            m_s1   = '0;
            m_s2   = '0;
            m_sw   = '0;
            m_mask = '0;
            m_intr = 1'b0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > DEB) void'(hist.pop_front());
            m_acc = '0;
            if (hist.size() == DEB) begin
                for (int b = 0; b < W; b++) begin
                    m_all = 1'b1;
                    for (int j = 0; j < DEB; j++) begin
                        if (hist[j][b] == m_sw[b]) m_all = 1'b0;
                    end
                    m_acc[b] = m_all;
                end
            end
`ifdef SW_INTR_LATCH_EN
            if (m_mask != '0) m_intr = 1'b1;
            else if (bus.INTR_ACK) m_intr = 1'b0;
`else
            m_intr = (m_acc != '0);
`endif
            m_sw   = m_sw ^ m_acc;
            m_mask = m_acc;
            m_s2   = m_s1;
            m_s1   = bus.SW_RAW;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one edge, then compare all outputs on the following falling edge.
    task automatic step(input logic [W-1:0] raw, input logic rst_v, input logic ack_v);
        bus.SW_RAW   = raw;
        RST          = rst_v;
        bus.INTR_ACK = ack_v;
        @(negedge CLK);
        check("switches", 32'(bus.SWITCHES), 32'(m_sw));
        check("mask", 32'(bus.CHANGE_MASK), 32'(m_mask));
        check("changed", 32'(bus.SW_CHANGED), 32'(m_mask != '0));
        check("intr", 32'(bus.INTR), 32'(m_intr));
    endtask

    int           n;
    logic         saw;
    logic [W-1:0] raw;

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        bus.SW_RAW   = '0;
        bus.INTR_ACK = 1'b0;
        RST          = 1'b1;

        // Reset then idle
        for (int i = 0; i < 3; i++) step(16'h0000, 1'b1, 1'b0);
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(16'h0000, 1'b0, 1'b0);
            if (bus.SWITCHES != '0 || bus.CHANGE_MASK != '0 || bus.SW_CHANGED || bus.INTR) saw = 1'b1;
        end
        check("t1_idle_zero", 32'(saw), 32'd0);

        // Single step latency
        step(16'h0001, 1'b0, 1'b0);
        n = 1;
        while (bus.SWITCHES != 16'h0001 && n < 20) begin
            step(16'h0001, 1'b0, 1'b0);
            n++;
        end
        check("t2_latency", 32'(n), 32'(DEB + 2));
        check("t2_mask", 32'(bus.CHANGE_MASK), 32'h0001);
        step(16'h0001, 1'b0, 1'b0);
        check("t2_one_pulse", 32'(bus.SW_CHANGED), 32'd0);

        // Short glitches on bit 3 must be rejected
        saw = 1'b0;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < DEB - 1; i++) begin
                step(16'h0009, 1'b0, 1'b0);
                if (bus.SW_CHANGED) saw = 1'b1;
            end
            for (int i = 0; i < DEB - 1; i++) begin
                step(16'h0001, 1'b0, 1'b0);
                if (bus.SW_CHANGED) saw = 1'b1;
            end
        end
        check("t3_no_change", 32'(saw), 32'd0);
        check("t3_bit3", 32'(bus.SWITCHES[3]), 32'd0);

        // Two bits flipping on one edge give one combined pulse
        step(16'h8000, 1'b0, 1'b0);
        n = 1;
        while (!bus.SW_CHANGED && n < 20) begin
            step(16'h8000, 1'b0, 1'b0);
            n++;
        end
        check("t4_latency", 32'(n), 32'(DEB + 2));
        check("t4_mask", 32'(bus.CHANGE_MASK), 32'h8001);
        check("t4_switches", 32'(bus.SWITCHES), 32'h8000);

        // Reset mid-count discards the partial count
        for (int i = 0; i < 5; i++) step(16'hFFFF, 1'b0, 1'b0);
        step(16'hFFFF, 1'b1, 1'b0);
        check("t5_reset_sw", 32'(bus.SWITCHES), 32'h0000);
        check("t5_reset_mask", 32'(bus.CHANGE_MASK), 32'h0000);
        step(16'hFFFF, 1'b0, 1'b0);
        n = 1;
        while (bus.SWITCHES != 16'hFFFF && n < 20) begin
            step(16'hFFFF, 1'b0, 1'b0);
            n++;
        end
        check("t5_latency", 32'(n), 32'(DEB + 2));
        check("t5_mask", 32'(bus.CHANGE_MASK), 32'hFFFF);

`ifdef SW_INTR_LATCH_EN
        for (int i = 0; i < 4; i++) step(16'hFFFF, 1'b0, 1'b0);
        check("t6_sticky", 32'(bus.INTR), 32'd1);
        step(16'hFFFF, 1'b0, 1'b1);
        check("t6_ack_clear", 32'(bus.INTR), 32'd0);
        step(16'hFFFE, 1'b0, 1'b0);
        n = 1;
        while (!bus.SW_CHANGED && n < 20) begin
            step(16'hFFFE, 1'b0, 1'b0);
            n++;
        end
        step(16'hFFFE, 1'b0, 1'b1);
        check("t6_set_wins", 32'(bus.INTR), 32'd1);
        step(16'hFFFE, 1'b0, 1'b1);
        check("t6_ack_again", 32'(bus.INTR), 32'd0);
`else
        step(16'hFFFF, 1'b0, 1'b1);
        check("t6_ack_ignored", 32'(bus.INTR), 32'd0);
`endif

        // Random bouncing switches, acks and rare resets
        raw = bus.SW_RAW;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) raw = raw ^ W'(1 << $urandom_range(0, W - 1));
            if ($urandom_range(0, 99) == 0) raw = W'($urandom);
            step(raw, ($urandom_range(0, 399) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
